// File: rtl/sbox_array_pipe_if.sv
// -----------------------------------------------------------------------------
// sbox_array_pipe_if
//   Beat-level handshake bundle for the S-box array pipeline.
//   Parameter:
//     NUM_LANES : byte lanes per beat (data width = 8*NUM_LANES).
//   Signals:
//     in_valid / in_ready  : upstream handshake.
//     in_inv               : per-beat mode (0 = forward, 1 = inverse).
//     in_data              : input bytes, lane i = in_data[8i+7:8i].
//     out_valid / out_ready: downstream handshake.
//     out_inv              : mode tag travelling with the beat.
//     out_data             : substituted bytes.
//     busy                 : any pipeline stage holds a beat.
//   Modports:
//     master : the side that produces input beats and consumes results.
//     slave  : the pipeline itself.
// -----------------------------------------------------------------------------
interface sbox_array_pipe_if #(
  parameter int NUM_LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_inv;
  logic [8*NUM_LANES-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_inv;
  logic [8*NUM_LANES-1:0] out_data;
  logic                   busy;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_inv, out_data, busy
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_inv, out_data, busy
  );
endinterface

// File: rtl/sbox_array_pipe.sv
// -----------------------------------------------------------------------------
// sbox_array_pipe
//   Pipelined array of AES S-boxes. Each lane computes S(x) or S^-1(x) on one
//   byte; both directions share one GF(2^8) inversion per lane, only the
//   affine layers in front of and behind the inversion differ:
//     forward : x -> inv(x) -> A(.) ^ 0x63
//     inverse : x -> A^-1(x ^ 0x63) -> inv(.)
//   The datapath is cut into three layers (input linear, inversion, output
//   affine). PIPE_STAGES chooses where registers sit:
//     1 : output register only
//     2 : register after input layer, then output register
//     3 : registers after input layer, after inversion, and at the output
//   Parameters: NUM_LANES (1..16), PIPE_STAGES (1..3), HAS_INV (0/1).
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     flush : synchronous clear of every in-flight beat
//     bus   : sbox_array_pipe_if.slave handshake bundle
// -----------------------------------------------------------------------------
module sbox_array_pipe #(
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 2,
  parameter int HAS_INV     = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  sbox_array_pipe_if.slave bus
);

  localparam int   W      = 8 * NUM_LANES;
  localparam logic INV_EN = (HAS_INV != 32'sd0);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    p = gf_mul(gf_mul(x, x), x);     // x^3
    p = gf_mul(gf_mul(p, p), x);     // x^7
    p = gf_mul(gf_mul(p, p), x);     // x^15
    p = gf_mul(gf_mul(p, p), x);     // x^31
    p = gf_mul(gf_mul(p, p), x);     // x^63
    p = gf_mul(gf_mul(p, p), x);     // x^127
    return gf_mul(p, p);             // x^254
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Forward affine: A(y) ^ 0x63
  function automatic logic [7:0] aff_fwd(input logic [7:0] y);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  // Inverse affine on the input side: linear part of A^-1 applied to x ^ 0x63
  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    logic [7:0] t;
    t = x ^ 8'h63;
    return rotl8(t, 1) ^ rotl8(t, 3) ^ rotl8(t, 6);
  endfunction

  function automatic logic [W-1:0] layer_in(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (INV_EN && inv) begin
        r[8*l +: 8] = aff_inv(d[8*l +: 8]);
      end else begin
        r[8*l +: 8] = d[8*l +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] layer_mid(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      r[8*l +: 8] = gf_inv(d[8*l +: 8]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] layer_out(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (INV_EN && inv) begin
        r[8*l +: 8] = d[8*l +: 8];
      end else begin
        r[8*l +: 8] = aff_fwd(d[8*l +: 8]);
      end
    end
    return r;
  endfunction

  logic [PIPE_STAGES-1:0] valid_r;
  logic [PIPE_STAGES-1:0] inv_r;
  logic [W-1:0]           data_r [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] ld_s;
  logic [PIPE_STAGES-1:0] v_in_s;
  logic [PIPE_STAGES-1:0] t_in_s;
  logic [W-1:0]           d_in_s [PIPE_STAGES];
  logic                   in_tag_s;

  assign in_tag_s = INV_EN & bus.in_inv;

  // Load enables: a stage loads if it, or any stage downstream, is empty, or
  // the output is being taken; bubbles therefore collapse.
  always_comb begin : ld_chain
    logic acc_s;
    acc_s = bus.out_ready;
    ld_s  = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      acc_s   = acc_s | ~valid_r[k];
      ld_s[k] = acc_s;
    end
  end

  // Valid and mode tag presented to each stage
  always_comb begin
    v_in_s    = '0;
    t_in_s    = '0;
    v_in_s[0] = bus.in_valid;
    t_in_s[0] = in_tag_s;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      v_in_s[k] = valid_r[k-1];
      t_in_s[k] = inv_r[k-1];
    end
  end

  generate
    if (PIPE_STAGES == 32'sd1) begin : g_p1
      // All three layers feed the single output register
      always_comb begin
        d_in_s[0] = layer_out(layer_mid(layer_in(bus.in_data, in_tag_s)), in_tag_s);
      end
    end else if (PIPE_STAGES == 32'sd2) begin : g_p2
      // Input layer registered, inversion and output layer in the last stage
      always_comb begin
        d_in_s[0] = layer_in(bus.in_data, in_tag_s);
        d_in_s[1] = layer_out(layer_mid(data_r[0]), inv_r[0]);
      end
    end else begin : g_p3
      // One layer per stage
      always_comb begin
        d_in_s[0] = layer_in(bus.in_data, in_tag_s);
        d_in_s[1] = layer_mid(data_r[0]);
        d_in_s[2] = layer_out(data_r[1], inv_r[1]);
      end
    end
  endgenerate

  // Stage registers; flush wins over any simultaneous load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      inv_r   <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_r[k] <= '0;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (ld_s[k]) begin
          valid_r[k] <= v_in_s[k];
          inv_r[k]   <= t_in_s[k];
          data_r[k]  <= d_in_s[k];
        end
      end
    end
  end

  assign bus.in_ready  = ld_s[0] & ~flush;
  assign bus.out_valid = valid_r[PIPE_STAGES-1];
  assign bus.out_inv   = inv_r[PIPE_STAGES-1];
  assign bus.out_data  = data_r[PIPE_STAGES-1];
  assign bus.busy      = |valid_r;

endmodule

// File: tb/tb_sbox_array_pipe.sv
// -----------------------------------------------------------------------------
// tb_sbox_array_pipe
//   Three instances (PIPE_STAGES = 1, 2, 3) share one stimulus stream. The
//   handshake follows the 2-stage instance; every instance pushes the
//   expected result of each beat it accepts into its own queue, and a monitor
//   pops and compares whenever that instance hands a beat downstream. The
//   reference table is the FIPS-197 S-box; its inverse is derived from it.
// -----------------------------------------------------------------------------
module tb_sbox_array_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sbox_array_pipe_if #(.NUM_LANES(4)) bus1 ();
  sbox_array_pipe_if #(.NUM_LANES(4)) bus2 ();
  sbox_array_pipe_if #(.NUM_LANES(4)) bus3 ();

  sbox_array_pipe #(.NUM_LANES(4), .PIPE_STAGES(1), .HAS_INV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
  sbox_array_pipe #(.NUM_LANES(4), .PIPE_STAGES(2), .HAS_INV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2));
  sbox_array_pipe #(.NUM_LANES(4), .PIPE_STAGES(3), .HAS_INV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus3));

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rows    [16];
  logic [32:0]  q1 [$];
  logic [32:0]  q2 [$];
  logic [32:0]  q3 [$];
  logic         stalled [1:3];
  logic [32:0]  held    [1:3];

  function automatic logic [32:0] expect_of(input logic inv, input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0;
    for (int l = 0; l < 4; l++) begin
      r[8*l +: 8] = inv ? isbox_t[d[8*l +: 8]] : sbox_t[d[8*l +: 8]];
    end
    return {inv, r};
  endfunction

  function automatic int qsize(input int g);
    case (g)
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [32:0] qpop(input int g);
    case (g)
      1:       return q1.pop_front();
      2:       return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard push: record the expected result of every accepted beat
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete(); q2.delete(); q3.delete();
    end else if (flush) begin
      q1.delete(); q2.delete(); q3.delete();
    end else begin
      if (bus1.in_valid && bus1.in_ready) q1.push_back(expect_of(bus1.in_inv, bus1.in_data));
      if (bus2.in_valid && bus2.in_ready) q2.push_back(expect_of(bus2.in_inv, bus2.in_data));
      if (bus3.in_valid && bus3.in_ready) q3.push_back(expect_of(bus3.in_inv, bus3.in_data));
    end
  end

  // Per-instance output check: ready rule from occupancy, hold under stall,
  // in-order data and tag
  task automatic mon(input int g, input int p, input logic ov, input logic ordy,
                     input logic oi, input logic ir, input logic [31:0] od);
    logic        exp_rdy;
    logic [32:0] e;
    exp_rdy = !flush && (ordy || qsize(g) < p);
    checks++;
    if (ir !== exp_rdy) begin
      failures++;
      $display("FAIL in_ready dut_p%0d got=%0b exp=%0b", p, ir, exp_rdy);
    end
    if (stalled[g]) begin
      checks++;
      if (!ov || {oi, od} !== held[g]) begin
        failures++;
        $display("FAIL hold_stable dut_p%0d got=%0b/%0h exp=1/%0h", p, ov, {oi, od}, held[g]);
      end
    end
    if (ov && ordy) begin
      checks++;
      if (qsize(g) == 0) begin
        failures++;
        $display("FAIL unexpected_out dut_p%0d got=%0h exp=none", p, {oi, od});
      end else begin
        e = qpop(g);
        if ({oi, od} !== e) begin
          failures++;
          $display("FAIL out_beat dut_p%0d got=%0h exp=%0h", p, {oi, od}, e);
        end
      end
    end
    stalled[g] <= ov && !ordy && !flush;
    held[g]    <= {oi, od};
  endtask

  // Monitor: sample all instances on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int g = 1; g <= 3; g++) stalled[g] <= 1'b0;
    end else begin
      mon(1, 1, bus1.out_valid, bus1.out_ready, bus1.out_inv, bus1.in_ready, bus1.out_data);
      mon(2, 2, bus2.out_valid, bus2.out_ready, bus2.out_inv, bus2.in_ready, bus2.out_data);
      mon(3, 3, bus3.out_valid, bus3.out_ready, bus3.out_inv, bus3.in_ready, bus3.out_data);
    end
  end

  task automatic set_in(input logic v, input logic inv, input logic [31:0] d);
    bus1.in_valid = v; bus1.in_inv = inv; bus1.in_data = d;
    bus2.in_valid = v; bus2.in_inv = inv; bus2.in_data = d;
    bus3.in_valid = v; bus3.in_inv = inv; bus3.in_data = d;
  endtask

  task automatic set_ordy(input logic r);
    bus1.out_ready = r; bus2.out_ready = r; bus3.out_ready = r;
  endtask

  // Present one beat until the 2-stage instance takes it (bounded)
  task automatic send(input logic inv, input logic [31:0] d);
    int   tries;
    logic acc;
    tries = 0;
    set_in(1'b1, inv, d);
    do begin
      @(negedge clk);
      acc = bus2.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=not_accepted exp=accepted data=%0h", d);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus1.busy || bus2.busy || bus3.busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 64'(bus1.busy | bus2.busy | bus3.busy), 64'd0);
  endtask

  // Single beat into empty pipes; out_valid must appear exactly P cycles later
  task automatic lat_test(input logic inv, input logic [31:0] d, input logic [31:0] exp);
    @(posedge clk);
    #1 set_in(1'b1, inv, d);
    @(posedge clk);
    #1 set_in(1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("lat_p1", 64'(bus1.out_valid), 64'(c == 1));
      chk("lat_p2", 64'(bus2.out_valid), 64'(c == 2));
      chk("lat_p3", 64'(bus3.out_valid), 64'(c == 3));
      if (c == 2) begin
        chk("vec_data_p2", 64'(bus2.out_data), 64'(exp));
        chk("vec_inv_p2", 64'(bus2.out_inv), 64'(inv));
      end
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return {8'(i * 17 + 5), 8'(i * 3 + 1), 8'(255 - i), 8'(i)};
  endfunction

  initial begin
    int          idx;
    int          cyc;
    logic        acc;
    logic        saw_drop;
    logic [6:0]  nn;
    logic [7:0]  base;

    rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        sbox_t[r * 16 + c] = rows[r][127 - 8 * c -: 8];
      end
    end
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    set_in(1'b0, 1'b0, 32'h0);
    set_ordy(1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid_p1", 64'(bus1.out_valid), 64'd0);
    chk("rst_out_valid_p2", 64'(bus2.out_valid), 64'd0);
    chk("rst_out_valid_p3", 64'(bus3.out_valid), 64'd0);
    chk("rst_busy_p2", 64'(bus2.busy), 64'd0);
    chk("rst_out_inv_p2", 64'(bus2.out_inv), 64'd0);
    chk("rst_out_data_p2", 64'(bus2.out_data), 64'd0);
    chk("rst_out_data_p3", 64'(bus3.out_data), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed vectors: forward and inverse
    lat_test(1'b0, 32'h53010000, 32'hED7C6363);
    lat_test(1'b1, 32'h00ED7C63, 32'h52530100);
    lat_test(1'b0, 32'h00FF1020, 32'h6316CAB7);

    // All 256 bytes in both modes, mode alternating every beat
    for (int n = 0; n < 128; n++) begin
      nn   = 7'(n);
      base = 8'((n % 64) * 4);
      send(nn[0] ^ nn[6], {base + 8'd3, base + 8'd2, base + 8'd1, base});
    end
    set_in(1'b0, 1'b0, 32'h0);
    wait_idle();

    // Backpressure: 10 beats, out_ready low for 5 cycles mid-stream
    idx      = 0;
    cyc      = 0;
    saw_drop = 1'b0;
    while (idx < 10 && cyc < 60) begin
      set_in(1'b1, idx[0], pat(idx));
      set_ordy(!(cyc >= 3 && cyc < 8));
      @(negedge clk);
      acc = bus2.in_ready;
      if (cyc >= 3 && cyc < 8 && !acc) saw_drop = 1'b1;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    set_in(1'b0, 1'b0, 32'h0);
    set_ordy(1'b1);
    chk("bp_in_ready_drop", 64'(saw_drop), 64'd1);
    chk("bp_all_sent", 64'(idx), 64'd10);
    wait_idle();

    // Flush with two beats held and a beat offered in the flush cycle
    set_ordy(1'b0);
    send(1'b0, 32'h11223344);
    send(1'b1, 32'h55667788);
    set_in(1'b1, 1'b0, 32'hAABBCCDD);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_p2", 64'(bus2.in_ready), 64'd0);
    chk("flush_busy_before_p2", 64'(bus2.busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    set_in(1'b0, 1'b0, 32'h0);
    set_ordy(1'b1);
    @(negedge clk);
    chk("flush_busy_p1", 64'(bus1.busy), 64'd0);
    chk("flush_busy_p2", 64'(bus2.busy), 64'd0);
    chk("flush_busy_p3", 64'(bus3.busy), 64'd0);
    chk("flush_out_valid_p2", 64'(bus2.out_valid), 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_accept_p2", 64'(bus2.out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream
    @(posedge clk);
    #1 set_in(1'b1, 1'b0, 32'h01020304);
    @(posedge clk);
    #1 set_in(1'b1, 1'b1, 32'hA0B0C0D0);
    @(posedge clk);
    #3;
    chk("pre_reset_out_valid_p2", 64'(bus2.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid_p1", 64'(bus1.out_valid), 64'd0);
    chk("async_rst_out_valid_p2", 64'(bus2.out_valid), 64'd0);
    chk("async_rst_out_valid_p3", 64'(bus3.out_valid), 64'd0);
    chk("async_rst_busy_p3", 64'(bus3.busy), 64'd0);
    set_in(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    lat_test(1'b0, 32'h00FF1020, 32'h6316CAB7);
    wait_idle();

    chk("sb_empty_p1", 64'(q1.size()), 64'd0);
    chk("sb_empty_p2", 64'(q2.size()), 64'd0);
    chk("sb_empty_p3", 64'(q3.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbox_array_pipe.md
Name: sbox_array_pipe

Overview:
- Parametrised, pipelined array of AES S-boxes for the round-based and port-serial AES datapaths.
- Each lane applies either the forward S-box or the inverse S-box to one byte.
- Forward and inverse share one GF(2^8) inversion core per lane; only the affine input and output layers differ.
- Elastic valid/ready pipeline with per-beat mode, a synchronous flush, and configurable latency.

Parameters:
- NUM_LANES, 4, number of byte lanes processed per beat (1..16).
- PIPE_STAGES, 2, register stages from input to output (1..3).
  - 1 = output register only.
  - 2 = adds a register after the input linear layer (T-signals).
  - 3 = also registers after the middle inversion layer (M-signals).
- HAS_INV, 1, 1 = inverse mode supported; 0 = mode input ignored, forward only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all in-flight beats.
- in_valid  input  1  input beat valid.
- in_ready  output  1  pipeline can accept the input beat this cycle.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat.
- in_data  input  8*NUM_LANES  lane i = in_data[8i+7:8i].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_inv  output  1  mode tag carried with the beat.
- out_data  output  8*NUM_LANES  lane i = S(x_i) or S^-1(x_i).
- busy  output  1  any stage holds a valid beat.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, out_inv and busy = 0; out_data = 0. Data registers may also clear to 0.
- Per-lane function, bit-exact to FIPS-197:
  - S(x) = A(x^-1) ^ 0x63.
  - S^-1(x) = (A^-1(x ^ 0x63))^-1, with 0^-1 = 0.
  - Lanes are independent; there is no cross-lane mixing.
- Each stage k holds valid_k, an inv tag and data.
- Stage k loads when valid_k == 0 or stage k+1 loads. The last stage loads when out_valid == 0 or out_ready == 1.
- in_ready = load enable of stage 1. This is a combinational path through the chain; no registered skid buffer.
- Transfer occurs when in_valid && in_ready. Stage 1 valid_next = in_valid, so a non-transfer loads a bubble.
- Latency: a beat accepted in cycle t appears at out_valid in cycle t+PIPE_STAGES if there is no backpressure.
- Throughput: 1 beat/cycle while out_ready stays high.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_inv are held stable.
  - Upstream bubbles collapse, so in_ready stays high until every stage is full.
  - No beat is lost or duplicated.
- Mode is per beat: consecutive beats may alternate in_inv with no bubble. Each beat's inv tag travels alongside its data.
- With HAS_INV=0: the affine-inverse path is not instantiated and out_inv = 0.
- flush: on the next edge all valid bits clear and busy drops. in_ready is forced 0 during the flush cycle, so nothing is accepted.
- flush has priority over simultaneous load. Reset mid-operation behaves like flush, asynchronously.
- busy = OR of all stage valid bits (registered-state based, no combinational input dependency).
- X handling: data in stages with valid = 0 is don't-care. out_data is defined only while out_valid = 1.

Test Plan:
1. NUM_LANES=4, PIPE_STAGES=2, forward: in_data=0x53_01_00_00 -> out_data=0xED_7C_63_63 two cycles later; out_inv=0.
2. Inverse: in_inv=1, in_data=0x00_ED_7C_63 -> out_data=0x52_53_01_00 (S^-1(0x00)=0x52).
3. Exhaustive: all 256 bytes in both modes, one per lane, each PIPE_STAGES in {1,2,3}, checked against a reference table. Alternate in_inv every beat and check the tags match.
4. Backpressure: stream 10 beats and hold out_ready=0 for 5 cycles mid-stream. Then:
   - in_ready drops after PIPE_STAGES beats are buffered;
   - out_data is stable while stalled;
   - all 10 results arrive in order.
5. Flush with 2 beats in flight and in_valid=1 -> next cycle busy=0, out_valid=0; the input beat in the flush cycle is not accepted.
6. Assert rst_n low asynchronously mid-stream -> out_valid=0 immediately. After release, the first accepted beat yields a correct result after PIPE_STAGES cycles.
